// File: rtl/mask_centroid_scan.sv
// mask_centroid_scan
//
// Walks the foreground mask RAM once per start pulse and accumulates frame statistics:
// foreground pixel count, sums of x and y (for a centroid), and the bounding box.
// Results are held until the next completed scan.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset (aborts a scan, clears outputs)
//   start         begin a scan; only sampled while idle
//   mask_rd_addr  mask RAM read address (0 when not scanning)
//   mask_rd_data  mask word, valid one cycle after mask_rd_addr; byte i is pixel x=col*16+i
//   busy          scan in progress, including the done cycle
//   done          one-cycle pulse, results updated this cycle
//   empty         last completed frame had no foreground pixels
//   fg_count      foreground pixel count
//   sum_x, sum_y  coordinate sums over foreground pixels
//   min_x, max_x  bounding box columns
//   min_y, max_y  bounding box rows
//
// Pipeline: address issue -> RAM read (1) -> per-block reduction register (1) -> accumulate (1),
// then a final cycle loads the output registers and raises done.

module mask_centroid_scan #(
  parameter int unsigned PIXELS_PER_BLOCK = 16,
  parameter int unsigned BLOCKS_PER_ROW   = 20,
  parameter int unsigned NUMBER_OF_ROWS   = 240,
  parameter int unsigned ADDR_W           = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mask_rd_addr,
  input  logic [127:0]      mask_rd_data,
  output logic              busy,
  output logic              done,
  output logic              empty,
  output logic [16:0]       fg_count,
  output logic [24:0]       sum_x,
  output logic [24:0]       sum_y,
  output logic [8:0]        min_x,
  output logic [8:0]        max_x,
  output logic [7:0]        min_y,
  output logic [7:0]        max_y
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BLOCKS_PER_ROW * NUMBER_OF_ROWS - 1);
  localparam logic [4:0]        LastCol  = 5'(BLOCKS_PER_ROW - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StFinish} state_e;

  state_e state_q, state_d;

  // Address generator with col/row counters riding alongside (no divider needed).
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        col_q;
  logic [7:0]        row_q;

  // Stage 1: RAM read in flight, coordinates of the word arriving on mask_rd_data.
  logic       rd_valid_q, rd_last_q;
  logic [4:0] rd_col_q;
  logic [7:0] rd_row_q;

  // Stage 2: per-block reduction.
  logic        blk_valid_q, blk_last_q;
  logic [4:0]  blk_cnt_q;
  logic [12:0] blk_sumx_q;
  logic [11:0] blk_sumy_q;
  logic [8:0]  blk_minx_q, blk_maxx_q;
  logic [7:0]  blk_row_q;

  // Stage 3: frame accumulators.
  logic        acc_last_q;
  logic [16:0] acc_cnt_q;
  logic [24:0] acc_sumx_q, acc_sumy_q;
  logic [8:0]  acc_minx_q, acc_maxx_q;
  logic [7:0]  acc_miny_q, acc_maxy_q;

  logic scan_start, finish_load;

  assign scan_start  = (state_q == StIdle) && start;
  assign finish_load = (state_q == StDrain) && acc_last_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StScan;
      StScan:   if (addr_q == LastAddr) state_d = StDrain;
      StDrain:  if (acc_last_q) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StFinish);
  assign mask_rd_addr = addr_q;

  // ---------------------------------------------------------------------------
  // Address / coordinate counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || scan_start) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (state_q == StScan) begin
      if (addr_q == LastAddr) begin
        // Hold address at 0 once the last word has been issued.
        addr_q <= '0;
        col_q  <= '0;
        row_q  <= '0;
      end else begin
        addr_q <= addr_q + 1'b1;
        if (col_q == LastCol) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: track the word currently being read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_col_q   <= '0;
      rd_row_q   <= '0;
    end else begin
      rd_valid_q <= (state_q == StScan);
      rd_last_q  <= (state_q == StScan) && (addr_q == LastAddr);
      rd_col_q   <= col_q;
      rd_row_q   <= row_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-block popcount, local x sum, first/last foreground byte
  // ---------------------------------------------------------------------------
  logic [4:0]  pop;
  logic [6:0]  lsum;
  logic [3:0]  first_idx, last_idx;
  logic [8:0]  xbase;
  logic [12:0] blk_sumx_d;
  logic [11:0] blk_sumy_d;

  always_comb begin
    pop       = '0;
    lsum      = '0;
    first_idx = '0;
    last_idx  = '0;
    // Descending scan leaves the lowest foreground index in first_idx.
    for (int i = PIXELS_PER_BLOCK - 1; i >= 0; i--) begin
      if (mask_rd_data[i*8 +: 8] != 8'd0) first_idx = 4'(i);
    end
    for (int i = 0; i < PIXELS_PER_BLOCK; i++) begin
      if (mask_rd_data[i*8 +: 8] != 8'd0) begin
        pop      = pop + 5'd1;
        lsum     = lsum + 7'(i);
        last_idx = 4'(i);
      end
    end
    xbase      = {rd_col_q, 4'b0000};
    blk_sumx_d = 13'(pop) * 13'(xbase) + 13'(lsum);
    blk_sumy_d = 12'(pop) * 12'(rd_row_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
      blk_cnt_q   <= '0;
      blk_sumx_q  <= '0;
      blk_sumy_q  <= '0;
      blk_minx_q  <= '0;
      blk_maxx_q  <= '0;
      blk_row_q   <= '0;
    end else begin
      blk_valid_q <= rd_valid_q;
      blk_last_q  <= rd_valid_q && rd_last_q;
      blk_cnt_q   <= pop;
      blk_sumx_q  <= blk_sumx_d;
      blk_sumy_q  <= blk_sumy_d;
      blk_minx_q  <= xbase + 9'(first_idx);
      blk_maxx_q  <= xbase + 9'(last_idx);
      blk_row_q   <= rd_row_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: frame accumulators
  // ---------------------------------------------------------------------------
  logic blk_has_fg;
  assign blk_has_fg = blk_valid_q && (blk_cnt_q != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_last_q <= 1'b0;
      acc_cnt_q  <= '0;
      acc_sumx_q <= '0;
      acc_sumy_q <= '0;
      acc_minx_q <= '0;
      acc_maxx_q <= '0;
      acc_miny_q <= '0;
      acc_maxy_q <= '0;
    end else if (scan_start) begin
      // Minima start at all-ones so the first foreground block always wins.
      acc_last_q <= 1'b0;
      acc_cnt_q  <= '0;
      acc_sumx_q <= '0;
      acc_sumy_q <= '0;
      acc_minx_q <= '1;
      acc_maxx_q <= '0;
      acc_miny_q <= '1;
      acc_maxy_q <= '0;
    end else begin
      acc_last_q <= blk_valid_q && blk_last_q;
      if (blk_has_fg) begin
        acc_cnt_q  <= acc_cnt_q + 17'(blk_cnt_q);
        acc_sumx_q <= acc_sumx_q + 25'(blk_sumx_q);
        acc_sumy_q <= acc_sumy_q + 25'(blk_sumy_q);
        if (blk_minx_q < acc_minx_q) acc_minx_q <= blk_minx_q;
        if (blk_maxx_q > acc_maxx_q) acc_maxx_q <= blk_maxx_q;
        if (blk_row_q < acc_miny_q)  acc_miny_q <= blk_row_q;
        if (blk_row_q > acc_maxy_q)  acc_maxy_q <= blk_row_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: held across scans, loaded as the FSM enters StFinish
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      empty    <= 1'b0;
      fg_count <= '0;
      sum_x    <= '0;
      sum_y    <= '0;
      min_x    <= '0;
      max_x    <= '0;
      min_y    <= '0;
      max_y    <= '0;
    end else if (finish_load) begin
      if (acc_cnt_q == 17'd0) begin
        // Empty frame reports an all-zero box rather than the sentinel minima.
        empty    <= 1'b1;
        fg_count <= '0;
        sum_x    <= '0;
        sum_y    <= '0;
        min_x    <= '0;
        max_x    <= '0;
        min_y    <= '0;
        max_y    <= '0;
      end else begin
        empty    <= 1'b0;
        fg_count <= acc_cnt_q;
        sum_x    <= acc_sumx_q;
        sum_y    <= acc_sumy_q;
        min_x    <= acc_minx_q;
        max_x    <= acc_maxx_q;
        min_y    <= acc_miny_q;
        max_y    <= acc_maxy_q;
      end
    end
  end

endmodule

// File: tb/tb_mask_centroid_scan.sv
// Directed bench for mask_centroid_scan: a behavioural mask RAM with one-cycle read latency,
// hand-computed expected statistics per frame, latency and handshake checks.

module tb_mask_centroid_scan;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [12:0]  mask_rd_addr;
  logic [127:0] mask_rd_data;
  logic         busy, done, empty;
  logic [16:0]  fg_count;
  logic [24:0]  sum_x, sum_y;
  logic [8:0]   min_x, max_x;
  logic [7:0]   min_y, max_y;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] mem [0:4799];

  always #5 clk = ~clk;

  always @(posedge clk) mask_rd_data <= mem[mask_rd_addr];

  mask_centroid_scan dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mask_rd_addr (mask_rd_addr),
    .mask_rd_data (mask_rd_data),
    .busy         (busy),
    .done         (done),
    .empty        (empty),
    .fg_count     (fg_count),
    .sum_x        (sum_x),
    .sum_y        (sum_y),
    .min_x        (min_x),
    .max_x        (max_x),
    .min_y        (min_y),
    .max_y        (max_y)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4800; i++) mem[i] = '0;
  endtask

  task automatic check_results(input string t, input int e_cnt, input int e_sx, input int e_sy,
                               input int e_mnx, input int e_mxx, input int e_mny,
                               input int e_mxy, input int e_empty);
    check_val({t, ".empty"}, 32'(empty), e_empty);
    check_val({t, ".fg_count"}, 32'(fg_count), e_cnt);
    check_val({t, ".sum_x"}, 32'(sum_x), e_sx);
    check_val({t, ".sum_y"}, 32'(sum_y), e_sy);
    check_val({t, ".min_x"}, 32'(min_x), e_mnx);
    check_val({t, ".max_x"}, 32'(max_x), e_mxx);
    check_val({t, ".min_y"}, 32'(min_y), e_mny);
    check_val({t, ".max_y"}, 32'(max_y), e_mxy);
  endtask

  // Starts a scan (start high for one cycle, sampled at edge E0) and waits for done.
  // With chain=0 it also pulses start during the done cycle and checks it is ignored.
  // With chain=1 it returns inside the done cycle so the next call raises start in the
  // cycle right after done.
  task automatic run_scan(input string t, input int prev_cnt, input bit chain);
    int cyc;
    bit seen;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);  // E0
    #1 start = 1'b0;
    check_val({t, ".busy_after_start"}, 32'(busy), 1);
    check_val({t, ".addr_first"}, 32'(mask_rd_addr), 0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 6000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) check_val({t, ".addr_second"}, 32'(mask_rd_addr), 1);
      if (cyc == 50) start = 1'b1;  // must be ignored while busy
      if (cyc == 51) start = 1'b0;
      if (cyc == 100) check_val({t, ".held_during_scan"}, 32'(fg_count), prev_cnt);
      if (done) seen = 1'b1;
    end
    check_val({t, ".done_latency"}, cyc, 4803);
    check_val({t, ".busy_in_done"}, 32'(busy), 1);
    if (!chain) begin
      start = 1'b1;  // in done cycle: ignored
      @(posedge clk);
      #1 start = 1'b0;
      check_val({t, ".idle_after_done"}, 32'(busy), 0);
      check_val({t, ".done_pulse_width"}, 32'(done), 0);
      @(posedge clk);
      #1;
      check_val({t, ".done_cycle_start_ignored"}, 32'(busy), 0);
    end
  endtask

  initial begin
    int done_seen;
    clear_mem();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("reset.busy", 32'(busy), 0);
    check_val("reset.done", 32'(done), 0);
    check_val("reset.addr", 32'(mask_rd_addr), 0);
    check_results("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // 1: all-zero mask
    run_scan("t1", 0, 1'b0);
    check_results("t1", 0, 0, 0, 0, 0, 0, 0, 1);

    // 2: single pixel at (0,0)
    mem[0] = 128'h01;
    run_scan("t2", 0, 1'b0);
    check_results("t2", 1, 0, 0, 0, 0, 0, 0, 0);

    // 3: single pixel at (319,239); chained so t4 starts the cycle after done
    clear_mem();
    mem[4799][127:120] = 8'hFF;
    run_scan("t3", 1, 1'b1);
    check_results("t3", 1, 319, 239, 319, 319, 239, 239, 0);

    // 4: full frame
    for (int i = 0; i < 4800; i++) mem[i] = '1;
    run_scan("t4", 1, 1'b0);
    check_results("t4", 76800, 12249600, 9177600, 0, 319, 0, 239, 0);

    // 5: (19,1) and (41,3)
    clear_mem();
    mem[21][31:24] = 8'h80;
    mem[62][79:72] = 8'h01;
    run_scan("t5", 76800, 1'b0);
    check_results("t5", 2, 60, 4, 19, 41, 1, 3, 0);

    // 6: reset at cycle 2000 of a scan, start pulses while busy, then restart
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);  // E0
    #1 start = 1'b0;
    for (int c = 1; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (c == 300 || c == 301) start = 1'b1;
      else start = 1'b0;
      if (c == 1000) check_val("t6.held_before_rst", 32'(fg_count), 2);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_val("t6.busy_after_rst", 32'(busy), 0);
    check_val("t6.addr_after_rst", 32'(mask_rd_addr), 0);
    check_results("t6_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    done_seen = 0;
    for (int c = 0; c < 4900; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check_val("t6.no_done_after_abort", done_seen, 0);
    run_scan("t6_restart", 0, 1'b0);
    check_results("t6_restart", 2, 60, 4, 19, 41, 1, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
